// File: rtl/store_req_fifo_pkg.sv
// Shared types and defaults for the store request queue.
// Holds the lsu_ctrl_t request payload and the default queue depth used when
// the queue is instantiated at the top level.
package store_req_fifo_pkg;

   localparam int unsigned ST_REQ_FIFO_DEPTH = 2;
   localparam int unsigned TRANS_ID_BITS     = 3;

   // Store/AMO request handed from the LSU issue path to the store unit.
   typedef struct packed {
      logic                     valid;
      logic [63:0]              vaddr;
      logic                     overflow;
      logic [63:0]              data;
      logic [7:0]               be;
      logic [3:0]               fu;
      logic [6:0]               operation;
      logic [TRANS_ID_BITS-1:0] trans_id;
   } lsu_ctrl_t;

endpackage

// File: rtl/store_req_fifo_mem.sv
// DEPTH-entry register array for the store request queue.
// Ports: clk_i clock; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o
// combinational indexed read.
module store_req_fifo_mem
   import store_req_fifo_pkg::*;
#(
   parameter  int unsigned DEPTH = ST_REQ_FIFO_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  lsu_ctrl_t        wdata_i,
   input  logic [PTR_W-1:0] raddr_i,
   output lsu_ctrl_t        rdata_o
);

   lsu_ctrl_t r_mem [DEPTH];

   // Payload storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         r_mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/store_req_fifo.sv
// Request queue upstream of the store unit, with combinational fall-through
// when empty so an idle store unit sees a new request in the issue cycle.
// Ports: clk_i/rst_ni clock and synchronous active-low reset; flush_i drops
// everything; valid_i/lsu_ctrl_i/ready_o push side; st_valid_o/st_ctrl_o/
// pop_st_i store-unit side; empty_o/usage_o occupancy status;
// full_cycles_o back-pressure cycle counter (only with STORE_REQ_FIFO_STATS_EN).
module store_req_fifo
   import store_req_fifo_pkg::*;
#(
   parameter  int unsigned DEPTH = ST_REQ_FIFO_DEPTH,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             valid_i,
   input  lsu_ctrl_t        lsu_ctrl_i,
   output logic             ready_o,
   output logic             st_valid_o,
   output lsu_ctrl_t        st_ctrl_o,
   input  logic             pop_st_i,
   output logic             empty_o,
   output logic [CNT_W-1:0] usage_o
`ifdef STORE_REQ_FIFO_STATS_EN
   ,
   output logic [31:0]      full_cycles_o
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   logic      w_empty, w_full, w_push, w_pop, w_bypass, w_write, w_pop_reg;
   lsu_ctrl_t w_rd_data;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));

   assign ready_o = !w_full;
   assign empty_o = w_empty;
   assign usage_o = r_count;

   assign w_push = valid_i && !w_full && !flush_i;

   // Head presentation: registered head when occupied, issue input when empty.
   always_comb begin
      st_valid_o = 1'b0;
      st_ctrl_o  = '0;
      if (w_empty) begin
         st_valid_o = w_push;
         if (w_push) begin
            st_ctrl_o = lsu_ctrl_i;
         end
      end else begin
         st_valid_o = !flush_i;
         st_ctrl_o  = w_rd_data;
      end
   end

   assign w_pop     = pop_st_i && st_valid_o;
   // An entry popped in its arrival cycle while empty never touches storage.
   assign w_bypass  = w_empty && w_push && pop_st_i;
   assign w_write   = w_push && !w_bypass;
   assign w_pop_reg = w_pop && !w_empty;

   // Pointer and occupancy state; flush returns to the reset state.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop_reg) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_write && !w_pop_reg) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_write && w_pop_reg) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   store_req_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (w_write),
      .waddr_i (r_wr_ptr),
      .wdata_i (lsu_ctrl_i),
      .raddr_i (r_rd_ptr),
      .rdata_o (w_rd_data)
   );

`ifdef STORE_REQ_FIFO_STATS_EN
   logic [31:0] r_full_cycles;

   // Saturating count of cycles where issue is held off by a full queue.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_full_cycles <= '0;
      end else if (w_full && valid_i && (r_full_cycles != 32'hFFFF_FFFF)) begin
         r_full_cycles <= r_full_cycles + 32'd1;
      end
   end

   assign full_cycles_o = r_full_cycles;
`endif

   // Protocol monitors: dropped pushes while full and pops with nothing valid.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(valid_i && w_full && !flush_i))
            else $warning("store_req_fifo: push while full dropped");
         assert (!(pop_st_i && !st_valid_o && !flush_i))
            else $warning("store_req_fifo: pop without valid head ignored");
      end
   end

endmodule

// File: tb/tb_store_req_fifo.sv
module tb_store_req_fifo;
   import store_req_fifo_pkg::*;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned NVEC  = 27;

   logic             clk = 1'b0;
   logic             rst_ni;
   logic             flush_i;
   logic             valid_i;
   lsu_ctrl_t        lsu_ctrl_i;
   logic             ready_o;
   logic             st_valid_o;
   lsu_ctrl_t        st_ctrl_o;
   logic             pop_st_i;
   logic             empty_o;
   logic [CNT_W-1:0] usage_o;
`ifdef STORE_REQ_FIFO_STATS_EN
   logic [31:0]      full_cycles_o;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   store_req_fifo #(.DEPTH(DEPTH)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .flush_i       (flush_i),
      .valid_i       (valid_i),
      .lsu_ctrl_i    (lsu_ctrl_i),
      .ready_o       (ready_o),
      .st_valid_o    (st_valid_o),
      .st_ctrl_o     (st_ctrl_o),
      .pop_st_i      (pop_st_i),
      .empty_o       (empty_o),
      .usage_o       (usage_o)
`ifdef STORE_REQ_FIFO_STATS_EN
      ,
      .full_cycles_o (full_cycles_o)
`endif
   );

   typedef struct {
      logic       flush;
      logic       valid;
      logic [2:0] id;
      logic       pop;
      logic       e_valid;
      logic [2:0] e_id;
      logic       e_ready;
      logic       e_empty;
      int         e_usage;
   } vec_t;

   vec_t vecs [NVEC];

   // Distinct payload per id so any field corruption is visible.
   function automatic lsu_ctrl_t mk(input logic [2:0] id);
      lsu_ctrl_t c;
      c.valid     = 1'b1;
      c.vaddr     = 64'h8000_1000 + 64'(id);
      c.overflow  = id[0];
      c.data      = {8{5'h15, id}};
      c.be        = 8'hF0 ^ 8'(id);
      c.fu        = 4'(id) + 4'd2;
      c.operation = 7'(id) + 7'd9;
      c.trans_id  = id;
      return c;
   endfunction

   function automatic vec_t mkv(input logic f, input logic v, input logic [2:0] id,
                                input logic p, input logic ev, input logic [2:0] eid,
                                input logic er, input logic ee, input int eu);
      vec_t r;
      r.flush = f; r.valid = v; r.id = id; r.pop = p;
      r.e_valid = ev; r.e_id = eid; r.e_ready = er; r.e_empty = ee; r.e_usage = eu;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic check_ctrl(input string name, input lsu_ctrl_t got, input lsu_ctrl_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got_id=%0d exp_id=%0d got=%h exp=%h", name,
                  got.trans_id, exp.trans_id, got, exp);
      end
   endtask

   task automatic drive(input logic f, input logic v, input logic [2:0] id, input logic p);
      flush_i    = f;
      valid_i    = v;
      lsu_ctrl_i = v ? mk(id) : '0;
      pop_st_i   = p;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ni = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   initial begin
      //               fl v  id    pop  ev eid   rdy emp use
      vecs[0]  = mkv(0, 0, 3'd0, 0,   0, 3'd0, 1,  1,  0); // idle after reset
      vecs[1]  = mkv(0, 1, 3'd3, 1,   1, 3'd3, 1,  1,  0); // bypass push+pop
      vecs[2]  = mkv(0, 0, 3'd0, 0,   0, 3'd0, 1,  1,  0); // nothing stored
      vecs[3]  = mkv(0, 1, 3'd1, 0,   1, 3'd1, 1,  1,  0); // push 1, fall-through view
      vecs[4]  = mkv(0, 1, 3'd2, 0,   1, 3'd1, 1,  0,  1); // push 2
      vecs[5]  = mkv(0, 1, 3'd5, 0,   1, 3'd1, 0,  0,  2); // push 5 while full: dropped
      vecs[6]  = mkv(0, 0, 3'd0, 1,   1, 3'd1, 0,  0,  2); // pop 1
      vecs[7]  = mkv(0, 0, 3'd0, 1,   1, 3'd2, 1,  0,  1); // pop 2
      vecs[8]  = mkv(0, 0, 3'd0, 0,   0, 3'd0, 1,  1,  0); // 5 never appears
      vecs[9]  = mkv(0, 1, 3'd4, 0,   1, 3'd4, 1,  1,  0); // push 4
      vecs[10] = mkv(0, 1, 3'd7, 1,   1, 3'd4, 1,  0,  1); // push 7, pop 4
      vecs[11] = mkv(0, 0, 3'd0, 0,   1, 3'd7, 1,  0,  1); // head 7, usage 1
      vecs[12] = mkv(0, 0, 3'd0, 1,   1, 3'd7, 1,  0,  1); // pop 7
      vecs[13] = mkv(0, 1, 3'd1, 0,   1, 3'd1, 1,  1,  0); // push 1
      vecs[14] = mkv(0, 1, 3'd2, 0,   1, 3'd1, 1,  0,  1); // push 2
      vecs[15] = mkv(0, 1, 3'd6, 1,   1, 3'd1, 0,  0,  2); // full: pop 1, push 6 refused
      vecs[16] = mkv(0, 0, 3'd0, 0,   1, 3'd2, 1,  0,  1); // only 2 left
      vecs[17] = mkv(0, 1, 3'd3, 0,   1, 3'd2, 1,  0,  1); // push 3 -> full
      vecs[18] = mkv(1, 1, 3'd5, 1,   0, 3'd0, 0,  0,  2); // flush with push+pop
      vecs[19] = mkv(0, 0, 3'd0, 0,   0, 3'd0, 1,  1,  0); // flushed empty
      vecs[20] = mkv(1, 1, 3'd6, 0,   0, 3'd0, 1,  1,  0); // flush kills empty push
      vecs[21] = mkv(0, 0, 3'd0, 0,   0, 3'd0, 1,  1,  0); // still empty
      vecs[22] = mkv(0, 1, 3'd1, 0,   1, 3'd1, 1,  1,  0); // pointer wrap run
      vecs[23] = mkv(0, 1, 3'd2, 1,   1, 3'd1, 1,  0,  1);
      vecs[24] = mkv(0, 1, 3'd3, 1,   1, 3'd2, 1,  0,  1);
      vecs[25] = mkv(0, 0, 3'd0, 1,   1, 3'd3, 1,  0,  1);
      vecs[26] = mkv(0, 0, 3'd0, 0,   0, 3'd0, 1,  1,  0);

      rst_ni = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 1'b0);
      do_reset();
      #1;
      check("reset_ctrl", 32'(st_ctrl_o.trans_id), 32'd0);
      check_ctrl("reset_ctrl_all", st_ctrl_o, '0);

      for (int i = 0; i < int'(NVEC); i++) begin
         @(negedge clk);
         drive(vecs[i].flush, vecs[i].valid, vecs[i].id, vecs[i].pop);
         #1;
         check($sformatf("v%0d_st_valid", i), 32'(st_valid_o), 32'(vecs[i].e_valid));
         check($sformatf("v%0d_ready", i), 32'(ready_o), 32'(vecs[i].e_ready));
         check($sformatf("v%0d_empty", i), 32'(empty_o), 32'(vecs[i].e_empty));
         check($sformatf("v%0d_usage", i), 32'(usage_o), 32'(vecs[i].e_usage));
         if (vecs[i].e_valid)
            check_ctrl($sformatf("v%0d_ctrl", i), st_ctrl_o, mk(vecs[i].e_id));
         else if (vecs[i].e_empty)
            check_ctrl($sformatf("v%0d_ctrl_zero", i), st_ctrl_o, '0);
      end

      // Reset in the middle of traffic clears occupied state.
      @(negedge clk); drive(1'b0, 1'b1, 3'd1, 1'b0);
      @(negedge clk); drive(1'b0, 1'b1, 3'd2, 1'b0);
      @(negedge clk); drive(1'b0, 1'b0, 3'd0, 1'b0);
      #1;
      check("pre_reset_usage", 32'(usage_o), 32'd2);
      do_reset();
      #1;
      check("post_reset_usage", 32'(usage_o), 32'd0);
      check("post_reset_empty", 32'(empty_o), 32'd1);
      check("post_reset_ready", 32'(ready_o), 32'd1);
      check("post_reset_valid", 32'(st_valid_o), 32'd0);

`ifdef STORE_REQ_FIFO_STATS_EN
      check("stats_reset", full_cycles_o, 32'd0);
      @(negedge clk); drive(1'b0, 1'b1, 3'd1, 1'b0);
      @(negedge clk); drive(1'b0, 1'b1, 3'd2, 1'b0);
      // Full with valid_i held for 10 cycles.
      repeat (10) begin
         @(negedge clk); drive(1'b0, 1'b1, 3'd5, 1'b0);
      end
      @(negedge clk); drive(1'b0, 1'b0, 3'd0, 1'b0);
      #1;
      check("stats_full10", full_cycles_o, 32'd10);
      @(negedge clk); drive(1'b1, 1'b0, 3'd0, 1'b0);
      @(negedge clk); drive(1'b0, 1'b0, 3'd0, 1'b0);
      #1;
      check("stats_after_flush", full_cycles_o, 32'd10);
      check("stats_flush_usage", 32'(usage_o), 32'd0);
      do_reset();
      #1;
      check("stats_after_reset", full_cycles_o, 32'd0);
`endif

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
